sr_latch_driver: RTL and testbench

- Command-side initiator for the gated SR latch: accepts set/reset/toggle/hold requests over a valid/ready handshake.
- Generates legal S/R/en excitation and checks the latch's Q/Qn feedback for confirmation.
- Reports per-command done/error status plus a saturating error count.
- Sits between control logic and the sr latch instance; it is the only block allowed to drive the latch's S, R and en inputs.

---
 rtl/sr_latch_driver_pkg.sv | 26 ++
 rtl/sr_latch_driver.sv | 145 ++++++++++++++
 tb/tb_sr_latch_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared encodings and helpers for the SR latch command driver.
`timescale 1ns/1ps
package sr_latch_driver_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned CNT_W   = 8;
    localparam logic [7:0]  ERR_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sr_latch_driver.sv
// Drives S/R/en of a gated SR latch per command and confirms the result on Q/Qn.
// Handshake: a command is taken on a rising edge where req_valid && req_ready; req_ready is high only in IDLE.
`timescale 1ns/1ps
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       S,
    output logic       R,
    output logic       en,
    input  logic       Q,
    input  logic       Qn,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_count,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_target;
    logic             r_s;
    logic             r_r;
    logic             r_en;
    logic             r_done;
    logic             r_err;
    logic             r_busy;
    logic             r_ready;
    logic [7:0]       r_err_count;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_target_nxt;
    logic             w_err_nxt;
    logic             w_hs;
    logic             w_pass;
    logic             w_invalid;
    logic             w_drive;

    assign w_hs      = req_valid && r_ready;
    assign w_pass    = (Q == r_target) && (Qn == ~r_target);
    assign w_invalid = (Q == Qn);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_cnt_nxt   = PULSE_LOAD;
                    w_state_nxt = ST_DRIVE;
                    case (op_e'(req_op))
                        OP_HOLD:   w_state_nxt  = ST_DONE;
                        OP_RESET:  w_target_nxt = 1'b0;
                        OP_SET:    w_target_nxt = 1'b1;
                        OP_TOGGLE: w_target_nxt = ~Q;
                        default:   w_state_nxt  = ST_DONE;
                    endcase
                end
            end
            ST_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_CHECK;
                    w_cnt_nxt   = TIMEOUT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_CHECK: begin
                // Pass is tested first so a late confirmation beats the timeout.
                if (w_pass) begin
                    w_state_nxt = ST_DONE;
                end else if (w_invalid || (r_cnt == '0)) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_drive = (w_state_nxt == ST_DRIVE);

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_target    <= 1'b0;
            r_s         <= 1'b0;
            r_r         <= 1'b0;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_err_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_s      <= w_drive && w_target_nxt;
            r_r      <= w_drive && !w_target_nxt;
            r_en     <= w_drive;
            r_done   <= (w_state_nxt == ST_DONE);
            r_err    <= (w_state_nxt == ST_DONE) && w_err_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_ready  <= (w_state_nxt == ST_IDLE);
            if ((w_state_nxt == ST_DONE) && w_err_nxt) begin
                r_err_count <= sat_inc(r_err_count);
            end
        end
    end

    assign req_ready = r_ready;
    assign S         = r_s;
    assign R         = r_r;
    assign en        = r_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: two instances (short and long pulse) against a behavioural latch.
`timescale 1ns/1ps
module tb_sr_latch_driver;
    import sr_latch_driver_pkg::*;

    localparam int P0 = 1;
    localparam int T0 = 4;
    localparam int P1 = 3;
    localparam int T1 = 4;
    localparam int EW = 26;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst[2];
    logic       req_valid[2];
    logic [1:0] req_op[2];
    logic       req_ready[2];
    logic       S[2];
    logic       R[2];
    logic       en[2];
    logic       Q[2];
    logic       Qn[2];
    logic       busy[2];
    logic       done[2];
    logic       err[2];
    logic [7:0] err_count[2];
    logic [1:0] dbg[2];
    logic [1:0] fmode[2];
    logic       watch_quiet = 1'b0;

    sr_latch_driver #(.PULSE_CYCLES(P0), .TIMEOUT(T0)) dut_a (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_op(req_op[0]),
        .req_ready(req_ready[0]), .S(S[0]), .R(R[0]), .en(en[0]), .Q(Q[0]), .Qn(Qn[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .err_count(err_count[0]),
        .dbg_state(dbg[0])
    );

    sr_latch_driver #(.PULSE_CYCLES(P1), .TIMEOUT(T1)) dut_b (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_op(req_op[1]),
        .req_ready(req_ready[1]), .S(S[1]), .R(R[1]), .en(en[1]), .Q(Q[1]), .Qn(Qn[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .err_count(err_count[1]),
        .dbg_state(dbg[1])
    );

    // Ideal gated latch; fmode 1 = Q stuck at 0, fmode 2 = Q and Qn both 1.
    for (genvar g = 0; g < 2; g++) begin : g_latch
        logic lq = 1'b0;
        always @(posedge clk) begin
            if (en[g]) begin
                if (S[g] && !R[g]) lq <= 1'b1;
                else if (R[g] && !S[g]) lq <= 1'b0;
            end
        end
        assign Q[g]  = (fmode[g] == 2'd1) ? 1'b0 : (fmode[g] == 2'd2) ? 1'b1 : lq;
        assign Qn[g] = (fmode[g] == 2'd0) ? ~lq : 1'b1;
    end

    // scoreboard
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int n_checks = 0;
    int n_fail   = 0;
    int ecnt0    = 0;
    int ecnt1    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_done(input string tag, input logic [EW-1:0] e, input int d);
        check({tag, "_err"},       32'(err[d]),       32'(e[25]));
        check({tag, "_q"},         32'(Q[d]),         32'(e[24]));
        check({tag, "_err_count"}, 32'(err_count[d]), 32'(e[23:16]));
        check({tag, "_done_cyc"},  32'(cyc[15:0]),    32'(e[15:0]));
    endtask

    // monitor
    always @(negedge clk) begin
        check("no_sr_a", 32'(S[0] && R[0]), 32'd0);
        check("no_sr_b", 32'(S[1] && R[1]), 32'd0);
        if (watch_quiet) check("quiet_a", 32'({S[0], R[0], en[0]}), 32'd0);
        if (done[0]) begin
            if (exp_q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done_a: got done=1 expected none (t=%0t)", $time);
            end else begin
                compare_done("done_a", exp_q0.pop_front(), 0);
            end
        end
        if (done[1]) begin
            if (exp_q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done_b: got done=1 expected none (t=%0t)", $time);
            end else begin
                compare_done("done_b", exp_q1.pop_front(), 1);
            end
        end
    end

    // driver tasks
    task automatic issue(input int d, input logic [1:0] op, input logic exp_err,
                         input logic exp_q, input int lat, input bit push);
        int waitc = 0;
        @(negedge clk);
        while (!req_ready[d] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready[d]) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
            return;
        end
        req_valid[d] = 1'b1;
        req_op[d]    = op;
        if (push) begin
            if (d == 0) begin
                if (exp_err && ecnt0 < 255) ecnt0++;
                exp_q0.push_back({exp_err, exp_q, 8'(ecnt0), 16'(cyc + 1 + lat)});
            end else begin
                if (exp_err && ecnt1 < 255) ecnt1++;
                exp_q1.push_back({exp_err, exp_q, 8'(ecnt1), 16'(cyc + 1 + lat)});
            end
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_op[d]    = 2'b00;
    endtask

    task automatic drain(input int d);
        int waitc = 0;
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got pending done expected none after 100 cycles");
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag, input int d);
        check({tag, "_S"},         32'(S[d]),         32'd0);
        check({tag, "_R"},         32'(R[d]),         32'd0);
        check({tag, "_en"},        32'(en[d]),        32'd0);
        check({tag, "_busy"},      32'(busy[d]),      32'd0);
        check({tag, "_done"},      32'(done[d]),      32'd0);
        check({tag, "_err"},       32'(err[d]),       32'd0);
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_err_count"}, 32'(err_count[d]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_op[0] = 2'b00; req_op[1] = 2'b00;
        fmode[0] = 2'd0; fmode[1] = 2'd0;
        #2;
        check_idle_outputs("reset_a", 0);
        check_idle_outputs("reset_b", 1);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // set, toggle, hold, toggle, reset: ideal latch, P0+1 edges to done
        issue(0, OP_SET, 1'b0, 1'b1, P0 + 1, 1'b1);
        drain(0);
        issue(0, OP_TOGGLE, 1'b0, 1'b0, P0 + 1, 1'b1);
        drain(0);
        watch_quiet = 1'b1;
        issue(0, OP_HOLD, 1'b0, 1'b0, 0, 1'b1);
        drain(0);
        watch_quiet = 1'b0;
        issue(0, OP_TOGGLE, 1'b0, 1'b1, P0 + 1, 1'b1);
        drain(0);
        issue(0, OP_RESET, 1'b0, 1'b0, P0 + 1, 1'b1);
        drain(0);

        // invalid feedback: Q==Qn fails on the first CHECK cycle
        fmode[0] = 2'd2;
        issue(0, OP_SET, 1'b1, 1'b1, P0 + 1, 1'b1);
        drain(0);
        fmode[0] = 2'd0;

        // stuck latch: every set times out after T0 CHECK cycles; count saturates
        fmode[0] = 2'd1;
        for (int i = 0; i < 300; i++) begin
            issue(0, OP_SET, 1'b1, 1'b0, P0 + T0, 1'b1);
            drain(0);
        end
        check("err_count_sat", 32'(err_count[0]), 32'd255);
        fmode[0] = 2'd0;

        #1 rst[0] = 1'b1;
        #1 check("err_count_cleared", 32'(err_count[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        ecnt0 = 0;

        // long pulse instance: reset lands in the middle of DRIVE
        issue(1, OP_SET, 1'b0, 1'b1, P1 + 1, 1'b0);
        check("drive_b_en", 32'(en[1]), 32'd1);
        check("drive_b_S",  32'(S[1]),  32'd1);
        check("drive_b_R",  32'(R[1]),  32'd0);
        @(negedge clk);
        #1 rst[1] = 1'b1;
        #1 check_idle_outputs("midrst_b", 1);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        repeat (P1 + 3) @(negedge clk);
        issue(1, OP_SET, 1'b0, 1'b1, P1 + 1, 1'b1);
        drain(1);
        issue(1, OP_RESET, 1'b0, 1'b0, P1 + 1, 1'b1);
        drain(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
